// File: rtl/rvh_pmp_mport.sv
// rvh_pmp_mport: multi-channel physical memory protection checker.
//
// Holds PMP_ENTRY_COUNT entries (cfg byte + pmpaddr) with OFF/TOR/NA4/NAPOT
// matching and lock semantics, and serves CHECK_PORT_COUNT independent check
// channels. Each channel has one registered response stage.
//
// Optional feature macro: RVH_PMP_MMWP_EN
//   When defined, adds mmwp_set_i and a sticky mmwp_q bit. While it is set,
//   an M-mode access that matches no entry faults.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   cfg_set_*               write one 64-bit cfg group (8 entries)
//   cfg_origin_payload_o    cfg group selected by cfg_set_addr_i (comb)
//   addr_set_*              write one pmpaddr
//   addr_origin_payload_o   pmpaddr selected by addr_set_addr_i (comb)
//   chk_vld_i/chk_rdy_o     per-channel request handshake
//   chk_paddr_i/type/priv   per-channel request payload
//   resp_vld_o/resp_rdy_i   per-channel response handshake
//   resp_fail/hit/idx_o     per-channel registered result
//   mmwp_set_i              (RVH_PMP_MMWP_EN only) set sticky MMWP
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A request is accepted whenever the response slot is empty or
// being drained in the same cycle; an undrained response keeps its payload
// stable until resp_rdy_i is seen.

module rvh_pmp_mport #(
  parameter int PMP_ENTRY_COUNT  = 16,
  parameter int CHECK_PORT_COUNT = 2,
  parameter int PADDR_WIDTH      = 56,
  parameter int PMPADDR_ID_WIDTH = $clog2(PMP_ENTRY_COUNT),
  parameter int PMPCFG_ID_WIDTH  = $clog2(PMP_ENTRY_COUNT/8)
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         cfg_set_vld_i,
  input  logic [PMPCFG_ID_WIDTH-1:0]                   cfg_set_addr_i,
  input  logic [63:0]                                  cfg_set_payload_i,
  output logic [63:0]                                  cfg_origin_payload_o,
  input  logic                                         addr_set_vld_i,
  input  logic [PMPADDR_ID_WIDTH-1:0]                  addr_set_addr_i,
  input  logic [63:0]                                  addr_set_payload_i,
  output logic [63:0]                                  addr_origin_payload_o,
`ifdef RVH_PMP_MMWP_EN
  input  logic                                         mmwp_set_i,
`endif
  input  logic [CHECK_PORT_COUNT-1:0]                  chk_vld_i,
  output logic [CHECK_PORT_COUNT-1:0]                  chk_rdy_o,
  input  logic [CHECK_PORT_COUNT*PADDR_WIDTH-1:0]      chk_paddr_i,
  input  logic [CHECK_PORT_COUNT*2-1:0]                chk_type_i,
  input  logic [CHECK_PORT_COUNT*2-1:0]                chk_priv_i,
  output logic [CHECK_PORT_COUNT-1:0]                  resp_vld_o,
  input  logic [CHECK_PORT_COUNT-1:0]                  resp_rdy_i,
  output logic [CHECK_PORT_COUNT-1:0]                  resp_fail_o,
  output logic [CHECK_PORT_COUNT-1:0]                  resp_hit_o,
  output logic [CHECK_PORT_COUNT*PMPADDR_ID_WIDTH-1:0] resp_idx_o
);

  localparam int N   = PMP_ENTRY_COUNT;
  localparam int CP  = CHECK_PORT_COUNT;
  localparam int AW  = PADDR_WIDTH - 2;
  localparam int IDW = PMPADDR_ID_WIDTH;

  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  localparam logic [AW-1:0] AW_ONE = AW'(1);

  // Stored cfg keeps only legal encodings: bits 6:5 are zero and the
  // reserved W=1,R=0 combination collapses to W=0.
  function automatic logic [7:0] cfg_sanitize(input logic [7:0] b);
    return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
  endfunction

  logic [7:0]    cfg_q      [N];
  logic [AW-1:0] addr_q     [N];
  logic [AW-1:0] prev_addr  [N];
  logic [AW-1:0] napot_care [N];
  logic [N-1:0]  addr_lock;
  logic          mmwp_active;

  // ---------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < N; e++) begin
        cfg_q[e]  <= '0;
        addr_q[e] <= '0;
      end
    end else begin
      if (cfg_set_vld_i) begin
        for (int e = 0; e < N; e++) begin
          if ((e / 8) == int'(cfg_set_addr_i) && !cfg_q[e][7]) begin
            cfg_q[e] <= cfg_sanitize(cfg_set_payload_i[(e % 8) * 8 +: 8]);
          end
        end
      end
      if (addr_set_vld_i) begin
        for (int e = 0; e < N; e++) begin
          if (e == int'(addr_set_addr_i) && !addr_lock[e]) begin
            addr_q[e] <= addr_set_payload_i[AW-1:0];
          end
        end
      end
    end
  end

  // An address is frozen by its own lock, and also when the next entry is a
  // locked TOR entry, since that entry uses this address as its lower bound.
  always_comb begin
    for (int e = 0; e < N - 1; e++) begin
      addr_lock[e] = cfg_q[e][7] | (cfg_q[e+1][7] & (cfg_q[e+1][4:3] == A_TOR));
    end
    addr_lock[N-1] = cfg_q[N-1][7];
  end

  // CSR readback
  always_comb begin
    cfg_origin_payload_o = '0;
    for (int e = 0; e < N; e++) begin
      if ((e / 8) == int'(cfg_set_addr_i)) begin
        cfg_origin_payload_o[(e % 8) * 8 +: 8] = cfg_q[e];
      end
    end
  end

  always_comb begin
    addr_origin_payload_o = '0;
    for (int e = 0; e < N; e++) begin
      if (e == int'(addr_set_addr_i)) begin
        addr_origin_payload_o = {{(64 - AW){1'b0}}, addr_q[e]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-entry matching helpers
  // ---------------------------------------------------------------------
  // x ^ (x + 1) sets bits 0..t where t is the trailing-ones count, so its
  // complement selects the bits that must compare equal. All-ones pmpaddr
  // wraps to zero and yields an empty care mask (match everything).
  always_comb begin
    for (int e = 0; e < N; e++) begin
      napot_care[e] = ~(addr_q[e] ^ (addr_q[e] + AW_ONE));
    end
  end

  always_comb begin
    prev_addr[0] = '0;
    for (int e = 1; e < N; e++) begin
      prev_addr[e] = addr_q[e-1];
    end
  end

`ifdef RVH_PMP_MMWP_EN
  logic mmwp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mmwp_q <= 1'b0;
    end else if (mmwp_set_i) begin
      mmwp_q <= 1'b1;
    end
  end

  assign mmwp_active = mmwp_q;
`else
  assign mmwp_active = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Per-channel check logic
  // ---------------------------------------------------------------------
  logic [AW-1:0]  c_a       [CP];
  logic [N-1:0]   match_vec [CP];
  logic [CP-1:0]  c_hit;
  logic [CP-1:0]  c_fail;
  logic [IDW-1:0] c_idx     [CP];
  logic [7:0]     c_cfg     [CP];

  always_comb begin
    for (int p = 0; p < CP; p++) begin
      c_a[p] = chk_paddr_i[p * PADDR_WIDTH + 2 +: AW];
    end
  end

  always_comb begin
    for (int p = 0; p < CP; p++) begin
      for (int e = 0; e < N; e++) begin
        case (cfg_q[e][4:3])
          A_TOR:   match_vec[p][e] = (prev_addr[e] <= c_a[p]) && (c_a[p] < addr_q[e]);
          A_NA4:   match_vec[p][e] = (c_a[p] == addr_q[e]);
          A_NAPOT: match_vec[p][e] = (((c_a[p] ^ addr_q[e]) & napot_care[e]) == '0);
          default: match_vec[p][e] = 1'b0;
        endcase
      end
    end
  end

  // Scan from the top so the lowest matching index is written last and wins.
  always_comb begin
    for (int p = 0; p < CP; p++) begin
      c_hit[p] = 1'b0;
      c_idx[p] = '0;
      c_cfg[p] = '0;
      for (int e = N - 1; e >= 0; e--) begin
        if (match_vec[p][e]) begin
          c_hit[p] = 1'b1;
          c_idx[p] = IDW'(e);
          c_cfg[p] = cfg_q[e];
        end
      end
    end
  end

  // cfg bits 0/1/2 are R/W/X, which lines up with type encodings 0/1/2.
  always_comb begin
    for (int p = 0; p < CP; p++) begin
      if (chk_type_i[p*2 +: 2] == 2'b11) begin
        c_fail[p] = 1'b1;
      end else if (c_hit[p]) begin
        c_fail[p] = !(((chk_priv_i[p*2 +: 2] == 2'b11) && !c_cfg[p][7]) ||
                      c_cfg[p][chk_type_i[p*2 +: 2]]);
      end else begin
        c_fail[p] = (chk_priv_i[p*2 +: 2] != 2'b11) || mmwp_active;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response stage
  // ---------------------------------------------------------------------
  logic [CP-1:0]     resp_vld_q;
  logic [CP-1:0]     resp_fail_q;
  logic [CP-1:0]     resp_hit_q;
  logic [CP*IDW-1:0] resp_idx_q;

  assign chk_rdy_o = ~resp_vld_q | resp_rdy_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_vld_q  <= '0;
      resp_fail_q <= '0;
      resp_hit_q  <= '0;
      resp_idx_q  <= '0;
    end else begin
      for (int p = 0; p < CP; p++) begin
        if (chk_vld_i[p] && chk_rdy_o[p]) begin
          resp_vld_q[p]             <= 1'b1;
          resp_fail_q[p]            <= c_fail[p];
          resp_hit_q[p]             <= c_hit[p];
          resp_idx_q[p*IDW +: IDW]  <= c_idx[p];
        end else if (resp_rdy_i[p]) begin
          resp_vld_q[p] <= 1'b0;
        end
      end
    end
  end

  assign resp_vld_o  = resp_vld_q;
  assign resp_fail_o = resp_fail_q;
  assign resp_hit_o  = resp_hit_q;
  assign resp_idx_o  = resp_idx_q;

  // Address bits that carry no protection information.
  logic unused_bits;
  always_comb begin
    unused_bits = ^addr_set_payload_i[63:AW];
    for (int p = 0; p < CP; p++) begin
      unused_bits = unused_bits ^ (^chk_paddr_i[p * PADDR_WIDTH +: 2]);
    end
  end

endmodule

// File: tb/tb_rvh_pmp_mport.sv
module tb_rvh_pmp_mport;

  localparam int N   = 16;
  localparam int CP  = 2;
  localparam int PW  = 56;
  localparam int IDW = 4;
  localparam int GW  = 1;
  localparam int AW  = PW - 2;
  localparam int EW  = 2 + IDW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_set_vld;
  logic [GW-1:0]     cfg_set_addr;
  logic [63:0]       cfg_set_payload;
  logic [63:0]       cfg_origin_payload;
  logic              addr_set_vld;
  logic [IDW-1:0]    addr_set_addr;
  logic [63:0]       addr_set_payload;
  logic [63:0]       addr_origin_payload;
  logic [CP-1:0]     chk_vld;
  logic [CP-1:0]     chk_rdy;
  logic [CP*PW-1:0]  chk_paddr;
  logic [CP*2-1:0]   chk_type;
  logic [CP*2-1:0]   chk_priv;
  logic [CP-1:0]     resp_vld;
  logic [CP-1:0]     resp_rdy;
  logic [CP-1:0]     resp_fail;
  logic [CP-1:0]     resp_hit;
  logic [CP*IDW-1:0] resp_idx;
`ifdef RVH_PMP_MMWP_EN
  logic              mmwp_set;
`endif

  rvh_pmp_mport #(
    .PMP_ENTRY_COUNT(N), .CHECK_PORT_COUNT(CP), .PADDR_WIDTH(PW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_set_vld_i(cfg_set_vld), .cfg_set_addr_i(cfg_set_addr),
    .cfg_set_payload_i(cfg_set_payload), .cfg_origin_payload_o(cfg_origin_payload),
    .addr_set_vld_i(addr_set_vld), .addr_set_addr_i(addr_set_addr),
    .addr_set_payload_i(addr_set_payload), .addr_origin_payload_o(addr_origin_payload),
`ifdef RVH_PMP_MMWP_EN
    .mmwp_set_i(mmwp_set),
`endif
    .chk_vld_i(chk_vld), .chk_rdy_o(chk_rdy), .chk_paddr_i(chk_paddr),
    .chk_type_i(chk_type), .chk_priv_i(chk_priv),
    .resp_vld_o(resp_vld), .resp_rdy_i(resp_rdy), .resp_fail_o(resp_fail),
    .resp_hit_o(resp_hit), .resp_idx_o(resp_idx)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  logic [7:0]      m_cfg [N];
  longint unsigned m_addr [N];
  bit              m_mmwp;
  logic [EW-1:0]   exp_q [CP][$];

  function automatic void m_clear();
    for (int e = 0; e < N; e++) begin
      m_cfg[e] = '0;
      m_addr[e] = 0;
    end
    m_mmwp = 0;
    for (int p = 0; p < CP; p++) exp_q[p].delete();
  endfunction

  function automatic void m_cfg_wr(int g, logic [63:0] pl);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b = pl[k*8 +: 8];
      if (!m_cfg[g*8+k][7]) begin
        m_cfg[g*8+k] = {b[7], 2'b00, b[4:3], b[2], (b[1] && b[0]), b[0]};
      end
    end
  endfunction

  function automatic void m_addr_wr(int i, longint unsigned v);
    bit locked;
    locked = m_cfg[i][7];
    if (i + 1 < N && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'd1) locked = 1;
    if (!locked) m_addr[i] = v & ((64'd1 << AW) - 1);
  endfunction

  function automatic logic [63:0] m_cfg_group(int g);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = m_cfg[g*8+k];
    return r;
  endfunction

  // Regions expressed as byte ranges [lo, hi).
  function automatic bit m_match(int e, longint unsigned pa);
    longint unsigned lo, hi, sz, base;
    int t;
    case (m_cfg[e][4:3])
      2'd1: begin
        lo = 0;
        if (e > 0) lo = m_addr[e-1] * 4;
        hi = m_addr[e] * 4;
        return (pa >= lo) && (pa < hi);
      end
      2'd2: return (pa >> 2) == m_addr[e];
      2'd3: begin
        t = 0;
        while (t < AW && m_addr[e][t]) t++;
        if (t >= AW) return 1;
        sz = 64'd1 << (t + 3);
        base = (m_addr[e] * 4) & ~(sz - 1);
        return (pa >= base) && (pa < base + sz);
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [EW-1:0] m_expect(longint unsigned pa, logic [1:0] typ, logic [1:0] priv);
    int hit_e;
    bit fail, is_m;
    logic [IDW-1:0] idx;
    hit_e = -1;
    is_m = (priv == 2'd3);
    for (int e = 0; e < N; e++) if (hit_e < 0 && m_match(e, pa)) hit_e = e;
    idx = '0;
    if (typ == 2'd3) fail = 1;
    else if (hit_e >= 0) fail = !((is_m && !m_cfg[hit_e][7]) || m_cfg[hit_e][typ]);
    else fail = !is_m || m_mmwp;
    if (hit_e >= 0) idx = IDW'(hit_e);
    return {fail, (hit_e >= 0), idx};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cfg_set_vld = 0; cfg_set_addr = '0; cfg_set_payload = '0;
    addr_set_vld = 0; addr_set_addr = '0; addr_set_payload = '0;
    chk_vld = '0; chk_paddr = '0; chk_type = '0; chk_priv = '0; resp_rdy = '0;
`ifdef RVH_PMP_MMWP_EN
    mmwp_set = 0;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    m_clear();
  endtask

  task automatic cfg_write(int g, logic [63:0] pl);
    cfg_set_vld = 1; cfg_set_addr = g[GW-1:0]; cfg_set_payload = pl;
    @(posedge clk); #1;
    cfg_set_vld = 0;
    m_cfg_wr(g, pl);
  endtask

  task automatic addr_write(int i, longint unsigned v);
    addr_set_vld = 1; addr_set_addr = i[IDW-1:0]; addr_set_payload = v;
    @(posedge clk); #1;
    addr_set_vld = 0;
    m_addr_wr(i, v);
  endtask

  task automatic set_req(int p, longint unsigned pa, logic [1:0] typ, logic [1:0] priv);
    chk_paddr[p*PW +: PW] = pa[PW-1:0];
    chk_type[p*2 +: 2] = typ;
    chk_priv[p*2 +: 2] = priv;
  endtask

  function automatic logic [EW-1:0] obs_resp(int p);
    return {resp_fail[p], resp_hit[p], resp_idx[p*IDW +: IDW]};
  endfunction

  // Single request with an always-ready response; returns the response seen
  // one cycle after acceptance.
  task automatic issue(int p, longint unsigned pa, logic [1:0] typ, logic [1:0] priv,
                       output logic [EW-1:0] obs, output logic vld);
    set_req(p, pa, typ, priv);
    chk_vld[p] = 1; resp_rdy[p] = 1;
    @(posedge clk); #1;
    chk_vld[p] = 0;
    obs = obs_resp(p);
    vld = resp_vld[p];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++; if (resp_vld !== '0) begin miscompares++; $display("FAIL reset_vld: got %b want 0", resp_vld); end
    vectors++; if (chk_rdy !== '1) begin miscompares++; $display("FAIL reset_rdy: got %b want 11", chk_rdy); end
    vectors++; if ({resp_fail, resp_hit, resp_idx} !== '0) begin miscompares++; $display("FAIL reset_resp: got %h want 0", {resp_fail, resp_hit, resp_idx}); end
    cfg_set_addr = 1; addr_set_addr = 5; #1;
    vectors++; if (cfg_origin_payload !== 64'd0) begin miscompares++; $display("FAIL reset_cfg: got %h want 0", cfg_origin_payload); end
    vectors++; if (addr_origin_payload !== 64'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", addr_origin_payload); end
  endtask

  task automatic test_default_priv();
    logic [EW-1:0] obs, exp;
    logic v;
    issue(0, 64'h8000_0000, 2'd0, 2'd0, obs, v);
    exp = m_expect(64'h8000_0000, 2'd0, 2'd0);
    vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL dflt_u_vld: got %b want 1", v); end
    vectors++; if (obs !== exp) begin miscompares++; $display("FAIL dflt_u: got %h want %h", obs, exp); end
    issue(0, 64'h8000_0000, 2'd0, 2'd3, obs, v);
    exp = m_expect(64'h8000_0000, 2'd0, 2'd3);
    vectors++; if (obs !== exp || v !== 1'b1) begin miscompares++; $display("FAIL dflt_m: got %h/%b want %h/1", obs, v, exp); end
  endtask

  task automatic test_napot();
    logic [EW-1:0] obs, exp;
    logic v;
    longint unsigned pas[3] = '{64'h8000_7FF8, 64'h8000_7FF8, 64'h8000_8000};
    logic [1:0] tys[3] = '{2'd1, 2'd2, 2'd0};
    cfg_write(0, 64'h1B);
    addr_write(0, 64'h2000_0FFF);
    for (int i = 0; i < 3; i++) begin
      issue(0, pas[i], tys[i], 2'd0, obs, v);
      exp = m_expect(pas[i], tys[i], 2'd0);
      vectors++; if (obs !== exp || v !== 1'b1) begin miscompares++; $display("FAIL napot_%0d: got %h/%b want %h/1", i, obs, v, exp); end
    end
  endtask

  task automatic test_tor();
    logic [EW-1:0] obs, exp;
    logic v;
    longint unsigned pas[4] = '{64'h1000, 64'h2000, 64'h1FFC, 64'h1800};
    logic [1:0] tys[4] = '{2'd0, 2'd0, 2'd2, 2'd1};
    cfg_write(0, 64'h0D00);
    addr_write(0, 64'h400);
    addr_write(1, 64'h800);
    for (int i = 0; i < 4; i++) begin
      issue(1, pas[i], tys[i], 2'd1, obs, v);
      exp = m_expect(pas[i], tys[i], 2'd1);
      vectors++; if (obs !== exp || v !== 1'b1) begin miscompares++; $display("FAIL tor_%0d: got %h/%b want %h/1", i, obs, v, exp); end
    end
  endtask

  task automatic test_lock();
    logic [EW-1:0] obs, exp;
    logic v;
    cfg_write(0, 64'h8D00);
    addr_write(0, 64'h0);
    cfg_write(0, 64'h7A_0000);
    addr_write(1, 64'h900);
    cfg_set_addr = 0; addr_set_addr = 0; #1;
    vectors++; if (cfg_origin_payload !== m_cfg_group(0)) begin miscompares++; $display("FAIL lock_cfg: got %h want %h", cfg_origin_payload, m_cfg_group(0)); end
    vectors++; if (addr_origin_payload !== m_addr[0]) begin miscompares++; $display("FAIL lock_addr0: got %h want %h", addr_origin_payload, m_addr[0]); end
    addr_set_addr = 1; #1;
    vectors++; if (addr_origin_payload !== m_addr[1]) begin miscompares++; $display("FAIL lock_addr1: got %h want %h", addr_origin_payload, m_addr[1]); end
    issue(0, 64'h1800, 2'd1, 2'd3, obs, v);
    exp = m_expect(64'h1800, 2'd1, 2'd3);
    vectors++; if (obs !== exp || v !== 1'b1) begin miscompares++; $display("FAIL lock_mw: got %h/%b want %h/1", obs, v, exp); end
    issue(0, 64'h1800, 2'd0, 2'd3, obs, v);
    exp = m_expect(64'h1800, 2'd0, 2'd3);
    vectors++; if (obs !== exp || v !== 1'b1) begin miscompares++; $display("FAIL lock_mr: got %h/%b want %h/1", obs, v, exp); end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] ea, eb, ec;
    ea = m_expect(64'h1000, 2'd0, 2'd1);
    eb = m_expect(64'h3000, 2'd2, 2'd0);
    ec = m_expect(64'h1800, 2'd0, 2'd3);
    resp_rdy[1] = 0; resp_rdy[0] = 1;
    set_req(1, 64'h1000, 2'd0, 2'd1); chk_vld[1] = 1;
    @(posedge clk); #1;
    set_req(1, 64'h3000, 2'd2, 2'd0);
    set_req(0, 64'h1800, 2'd0, 2'd3); chk_vld[0] = 1;
    #1;
    vectors++; if (chk_rdy[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_rdy1_lo: got %b want 0", chk_rdy[1]); end
    vectors++; if (resp_vld[1] !== 1'b1 || obs_resp(1) !== ea) begin miscompares++; $display("FAIL b2b_a: got %h/%b want %h/1", obs_resp(1), resp_vld[1], ea); end
    vectors++; if (chk_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_rdy0: got %b want 1", chk_rdy[0]); end
    @(posedge clk); #1;
    chk_vld[0] = 0;
    vectors++; if (resp_vld[1] !== 1'b1 || obs_resp(1) !== ea) begin miscompares++; $display("FAIL b2b_a_held: got %h/%b want %h/1", obs_resp(1), resp_vld[1], ea); end
    vectors++; if (resp_vld[0] !== 1'b1 || obs_resp(0) !== ec) begin miscompares++; $display("FAIL b2b_ch0: got %h/%b want %h/1", obs_resp(0), resp_vld[0], ec); end
    resp_rdy[1] = 1; #1;
    vectors++; if (chk_rdy[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_rdy1_hi: got %b want 1", chk_rdy[1]); end
    @(posedge clk); #1;
    chk_vld[1] = 0;
    vectors++; if (resp_vld[1] !== 1'b1 || obs_resp(1) !== eb) begin miscompares++; $display("FAIL b2b_b: got %h/%b want %h/1", obs_resp(1), resp_vld[1], eb); end
    @(posedge clk); #1;
    vectors++; if (resp_vld !== 2'b00) begin miscompares++; $display("FAIL b2b_drain: got %b want 00", resp_vld); end
  endtask

  function automatic longint unsigned rand_pmpaddr();
    int k;
    case ($urandom_range(0, 7))
      0, 1, 2: return longint'($urandom_range(0, 'hFFF));
      7:       return (64'd1 << AW) - 1;
      default: begin
        k = $urandom_range(0, 8);
        return (longint'($urandom_range(0, 'h3F)) << (k + 1)) | ((64'd1 << k) - 1);
      end
    endcase
  endfunction

  // Full-throughput random traffic on both channels with concurrent CSR
  // writes and random response backpressure.
  task automatic test_random();
    longint unsigned pa;
    logic [1:0] ty, pv;
    logic [63:0] cpl;
    int g, ai;
    longint unsigned av;
    bit do_cfg, do_addr, active;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      active = (cyc < 590);
      for (int p = 0; p < CP; p++) begin
        resp_rdy[p] = active ? ($urandom_range(0, 3) != 0) : 1'b1;
        vectors++;
        if (resp_vld[p] !== (exp_q[p].size() != 0)) begin
          miscompares++; $display("FAIL rand_vld p%0d cyc%0d: got %b want %0d", p, cyc, resp_vld[p], exp_q[p].size());
        end
        if (resp_vld[p] && exp_q[p].size() != 0) begin
          vectors++;
          if (obs_resp(p) !== exp_q[p][0]) begin
            miscompares++; $display("FAIL rand_resp p%0d cyc%0d: got %h want %h", p, cyc, obs_resp(p), exp_q[p][0]);
          end
          if (resp_rdy[p]) void'(exp_q[p].pop_front());
        end
        chk_vld[p] = active && ($urandom_range(0, 2) != 0);
        set_req(p, longint'($urandom_range(0, 'h7FFF)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      do_cfg = active && ($urandom_range(0, 5) == 0);
      do_addr = active && ($urandom_range(0, 3) == 0);
      g = $urandom_range(0, 1);
      for (int k = 0; k < 8; k++) begin
        cpl[k*8 +: 8] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 15) != 0) cpl[k*8+7] = 1'b0;
      end
      ai = $urandom_range(0, N - 1);
      av = rand_pmpaddr();
      cfg_set_vld = do_cfg; cfg_set_addr = g[GW-1:0]; cfg_set_payload = cpl;
      addr_set_vld = do_addr; addr_set_addr = ai[IDW-1:0]; addr_set_payload = av;
      #1;
      for (int p = 0; p < CP; p++) begin
        vectors++;
        if (chk_rdy[p] !== (!resp_vld[p] || resp_rdy[p])) begin
          miscompares++; $display("FAIL rand_rdy p%0d cyc%0d: got %b", p, cyc, chk_rdy[p]);
        end
        if (chk_vld[p] && chk_rdy[p]) begin
          pa = chk_paddr[p*PW +: PW];
          ty = chk_type[p*2 +: 2];
          pv = chk_priv[p*2 +: 2];
          exp_q[p].push_back(m_expect(pa, ty, pv));
        end
      end
      if (do_cfg) m_cfg_wr(g, cpl);
      if (do_addr) m_addr_wr(ai, av);
    end
    drive_idle();
  endtask

  task automatic test_reset_midflight();
    resp_rdy = '0;
    set_req(0, 64'h40, 2'd0, 2'd0); set_req(1, 64'h80, 2'd1, 2'd3);
    chk_vld = '1;
    @(posedge clk); #1;
    chk_vld = '0;
    vectors++; if (resp_vld !== 2'b11) begin miscompares++; $display("FAIL mid_pending: got %b want 11", resp_vld); end
    rstn = 0; #1;
    vectors++; if (resp_vld !== 2'b00) begin miscompares++; $display("FAIL mid_vld: got %b want 00", resp_vld); end
    vectors++; if ({resp_fail, resp_hit, resp_idx} !== '0) begin miscompares++; $display("FAIL mid_resp: got %h want 0", {resp_fail, resp_hit, resp_idx}); end
    cfg_set_addr = 0; addr_set_addr = 3; #1;
    vectors++; if (cfg_origin_payload !== 64'd0 || addr_origin_payload !== 64'd0) begin miscompares++; $display("FAIL mid_csr: got %h %h want 0", cfg_origin_payload, addr_origin_payload); end
    @(posedge clk); #1 rstn = 1;
    m_clear();
  endtask

`ifdef RVH_PMP_MMWP_EN
  task automatic test_mmwp();
    logic [EW-1:0] obs, exp;
    logic v;
    mmwp_set = 1;
    @(posedge clk); #1;
    mmwp_set = 0; m_mmwp = 1;
    issue(0, 64'h7000_0000, 2'd0, 2'd3, obs, v);
    exp = m_expect(64'h7000_0000, 2'd0, 2'd3);
    vectors++; if (obs !== exp || v !== 1'b1) begin miscompares++; $display("FAIL mmwp_set: got %h/%b want %h/1", obs, v, exp); end
    do_reset();
    issue(0, 64'h7000_0000, 2'd0, 2'd3, obs, v);
    exp = m_expect(64'h7000_0000, 2'd0, 2'd3);
    vectors++; if (obs !== exp || v !== 1'b1) begin miscompares++; $display("FAIL mmwp_clr: got %h/%b want %h/1", obs, v, exp); end
  endtask
`endif

  initial begin
    drive_idle();
    do_reset();
    test_reset();
    test_default_priv();
    test_napot();
    test_tor();
    test_lock();
    test_back_to_back();
    do_reset();
    test_random();
    test_reset_midflight();
`ifdef RVH_PMP_MMWP_EN
    test_mmwp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
